perf_counter_copy_arbiter: RTL and testbench

PERF_COUNTER_COPY_ARBITER -- requirements
Module: perf_counter_copy_arbiter

---
 rtl/perf_counter_copy_arbiter_pkg.sv | 43 ++++
 rtl/perf_counter_copy_arbiter_if.sv | 33 +++
 rtl/perf_counter_copy_arbiter_divider.sv | 89 ++++++++
 rtl/perf_counter_copy_arbiter.sv | 159 +++++++++++++++
 tb/tb_perf_counter_copy_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_counter_copy_arbiter_pkg.sv
// Shared definitions for the perf-counter copy arbiter: FSM encoding,
// requester indices, count widths and the round-robin pick helper.
package perf_mon_pkg;

  localparam int PROG_CNT_W  = 10;
  localparam int READ_CNT_W  = 12;
  localparam int ERASE_CNT_W = 10;
  localparam int REQ_CNT_W   = 12;

  localparam logic [1:0] SEL_PROG  = 2'd0;
  localparam logic [1:0] SEL_READ  = 2'd1;
  localparam logic [1:0] SEL_ERASE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_DIV       = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_CMPLT     = 3'd4,
    ST_DROP_WAIT = 3'd5
  } state_e;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : 2'(idx + 2'd1);
  endfunction

  // First asserted requester at or after ptr, in prog/read/erase order.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    idx     = ptr;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = rr_next(idx);
    end
  endfunction

endpackage

// File: rtl/perf_counter_copy_arbiter_if.sv
// Snapshot bus between the arbiter (master) and the register bus (slave).
// o_snap_avg exists only when PERF_AVG_DIV_EN is defined.
interface perf_counter_copy_arbiter_if #(
  parameter int SLV_DATA_WD = 32
);
  // Handshake: the snapshot is offered while o_snap_valid=1 and held stable;
  // a cycle with o_snap_valid=1 and i_snap_ack=1 consumes it. Ack is ignored otherwise.
  logic                   o_snap_valid;
  logic [1:0]             o_snap_sel;
  logic [SLV_DATA_WD-1:0] o_snap_sum;
  logic [11:0]            o_snap_req_cnt;
`ifdef PERF_AVG_DIV_EN
  logic [SLV_DATA_WD-1:0] o_snap_avg;
`endif
  logic                   i_snap_ack;

  modport master (
    output o_snap_valid, o_snap_sel, o_snap_sum, o_snap_req_cnt,
`ifdef PERF_AVG_DIV_EN
    output o_snap_avg,
`endif
    input  i_snap_ack
  );

  modport slave (
    input  o_snap_valid, o_snap_sel, o_snap_sum, o_snap_req_cnt,
`ifdef PERF_AVG_DIV_EN
    input  o_snap_avg,
`endif
    output i_snap_ack
  );

endinterface

// File: rtl/perf_counter_copy_arbiter_divider.sv
// perf_avg_divider: restoring divider, one quotient bit per cycle, W cycles per
// divide. o_done is high in the cycle whose edge writes the final quotient.
module perf_avg_divider #(
  parameter int W  = 32,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [W-1:0]  i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_done,
  output logic [W-1:0]  o_quotient
);
  localparam int CW = $clog2(W + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic          zero_q, zero_d;
  logic [W-1:0]  result_q, result_d;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          take;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;

  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    diff     = shifted - {1'b0, dvsr_q};
    take     = (shifted >= {1'b0, dvsr_q});
    rem_step = take ? diff[W-1:0] : shifted[W-1:0];
    quo_step = {quo_q[W-2:0], take};
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    zero_d   = zero_q;
    result_d = result_q;
    if (i_start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(W);
      rem_d  = '0;
      quo_d  = i_dividend;
      dvsr_d = {{(W-DW){1'b0}}, i_divisor};
      zero_d = (i_divisor == '0);
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d   = 1'b0;
        // Divide-by-zero reports 0 rather than the all-ones restoring result.
        result_d = zero_q ? '0 : quo_step;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign o_done     = busy_q && (cnt_q == CW'(1));
  assign o_quotient = result_q;

endmodule

// File: rtl/perf_counter_copy_arbiter.sv
// Round-robin copy-out arbiter for the prog/read/erase perf counters.
// Define PERF_AVG_DIV_EN to add the DIV state and the sum/req_cnt average.
module perf_counter_copy_arbiter
  import perf_mon_pkg::*;
#(
  parameter int         SLV_DATA_WD = 32,
  parameter logic [1:0] RR_INIT     = 2'd0
) (
  input  logic                   i_bus_clk,
  input  logic                   i_bus_rst,
  input  logic                   i_prog_ready,
  input  logic                   i_read_ready,
  input  logic                   i_erase_ready,
  input  logic [SLV_DATA_WD-1:0] i_prog_cnt,
  input  logic [SLV_DATA_WD-1:0] i_read_cnt,
  input  logic [SLV_DATA_WD-1:0] i_erase_cnt,
  input  logic [PROG_CNT_W-1:0]  i_prog_req_cnt,
  input  logic [READ_CNT_W-1:0]  i_read_req_cnt,
  input  logic [ERASE_CNT_W-1:0] i_erase_req_cnt,
  output logic                   o_prog_cp_cmplt,
  output logic                   o_read_cp_cmplt,
  output logic                   o_erase_cp_cmplt,
  output logic                   o_busy,
  output state_e                 o_dbg_state,
  perf_counter_copy_arbiter_if.master snap
);

  state_e                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [1:0]             sel_q, sel_d;
  logic                   valid_q, valid_d;
  logic [SLV_DATA_WD-1:0] sum_q, sum_d;
  logic [REQ_CNT_W-1:0]   req_q, req_d;
  logic [2:0]             cmplt_q, cmplt_d;

  logic [3:0]             ready_vec;
  logic [1:0]             grant;
  logic [SLV_DATA_WD-1:0] cap_sum;
  logic [REQ_CNT_W-1:0]   cap_req;
  logic                   div_done;

  assign ready_vec = {1'b0, i_erase_ready, i_read_ready, i_prog_ready};
  assign grant     = rr_pick(ready_vec, ptr_q);

  always_comb begin
    cap_sum = sum_q;
    cap_req = req_q;
    case (sel_q)
      SEL_PROG:  begin cap_sum = i_prog_cnt;  cap_req = {2'b00, i_prog_req_cnt};  end
      SEL_READ:  begin cap_sum = i_read_cnt;  cap_req = i_read_req_cnt;           end
      SEL_ERASE: begin cap_sum = i_erase_cnt; cap_req = {2'b00, i_erase_req_cnt}; end
      default:   ;
    endcase
  end

`ifdef PERF_AVG_DIV_EN
  logic [SLV_DATA_WD-1:0] avg;

  perf_avg_divider #(
    .W  (SLV_DATA_WD),
    .DW (REQ_CNT_W)
  ) u_div (
    .clk        (i_bus_clk),
    .rst        (i_bus_rst),
    .i_start    (state_q == ST_CAPTURE),
    .i_dividend (cap_sum),
    .i_divisor  (cap_req),
    .o_done     (div_done),
    .o_quotient (avg)
  );

  assign snap.o_snap_avg = avg;
`else
  assign div_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    req_d   = req_q;
    cmplt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|ready_vec) begin
          sel_d   = grant;
          ptr_d   = rr_next(grant);
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        sum_d = cap_sum;
        req_d = cap_req;
`ifdef PERF_AVG_DIV_EN
        state_d = ST_DIV;
`else
        state_d = ST_PRESENT;
        valid_d = 1'b1;
`endif
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_PRESENT;
          valid_d = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (snap.i_snap_ack) begin
          valid_d = 1'b0;
          cmplt_d = 3'(3'b001 << sel_q);
          state_d = ST_CMPLT;
        end
      end
      ST_CMPLT: state_d = ST_DROP_WAIT;
      // Hold here until the granted counter drops ready so one copy is never granted twice.
      ST_DROP_WAIT: begin
        if (!ready_vec[sel_q]) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_bus_clk or posedge i_bus_rst) begin
    if (i_bus_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= RR_INIT;
      sel_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      req_q   <= '0;
      cmplt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      req_q   <= req_d;
      cmplt_q <= cmplt_d;
    end
  end

  assign snap.o_snap_valid   = valid_q;
  assign snap.o_snap_sel     = sel_q;
  assign snap.o_snap_sum     = sum_q;
  assign snap.o_snap_req_cnt = req_q;

  assign o_prog_cp_cmplt  = cmplt_q[0];
  assign o_read_cp_cmplt  = cmplt_q[1];
  assign o_erase_cp_cmplt = cmplt_q[2];
  assign o_busy           = (state_q != ST_IDLE);
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_perf_counter_copy_arbiter.sv
// Directed bench for perf_counter_copy_arbiter; honours PERF_AVG_DIV_EN
// for snapshot latency and average checks.
module tb_perf_counter_copy_arbiter;
  import perf_mon_pkg::*;

  localparam int W = 32;
`ifdef PERF_AVG_DIV_EN
  localparam int LAT = 2 + W;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rst;
  logic          prog_ready, read_ready, erase_ready;
  logic [W-1:0]  prog_cnt, read_cnt, erase_cnt;
  logic [9:0]    prog_req;
  logic [11:0]   read_req;
  logic [9:0]    erase_req;
  logic          prog_cmplt, read_cmplt, erase_cmplt;
  logic          busy;
  state_e        dbg_state;
  logic [2:0]    pulses;

  int n_checks;
  int n_errors;

  perf_counter_copy_arbiter_if #(.SLV_DATA_WD(W)) snap_bus ();

  perf_counter_copy_arbiter #(.SLV_DATA_WD(W), .RR_INIT(2'd0)) dut (
    .i_bus_clk        (clk),
    .i_bus_rst        (rst),
    .i_prog_ready     (prog_ready),
    .i_read_ready     (read_ready),
    .i_erase_ready    (erase_ready),
    .i_prog_cnt       (prog_cnt),
    .i_read_cnt       (read_cnt),
    .i_erase_cnt      (erase_cnt),
    .i_prog_req_cnt   (prog_req),
    .i_read_req_cnt   (read_req),
    .i_erase_req_cnt  (erase_req),
    .o_prog_cp_cmplt  (prog_cmplt),
    .o_read_cp_cmplt  (read_cmplt),
    .o_erase_cp_cmplt (erase_cmplt),
    .o_busy           (busy),
    .o_dbg_state      (dbg_state),
    .snap             (snap_bus)
  );

  assign pulses = {erase_cmplt, read_cmplt, prog_cmplt};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time expired, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [1:0] sel, input logic v);
    case (sel)
      SEL_PROG:  prog_ready  = v;
      SEL_READ:  read_ready  = v;
      default:   erase_ready = v;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait for the snapshot, check it, ack, check the pulse, drop ready, back to IDLE.
  task automatic serve(input string tag, input logic [1:0] sel,
                       input logic [W-1:0] sum, input logic [11:0] req);
    int waited;
    waited = 0;
    while (!snap_bus.o_snap_valid && waited < 100) begin
      tick();
      waited++;
    end
    check_eq({tag, "_valid"}, snap_bus.o_snap_valid, 1'b1);
    check_eq({tag, "_sel"}, snap_bus.o_snap_sel, sel);
    check_eq({tag, "_sum"}, snap_bus.o_snap_sum, sum);
    check_eq({tag, "_req"}, snap_bus.o_snap_req_cnt, req);
    snap_bus.i_snap_ack = 1'b1;
    tick();
    snap_bus.i_snap_ack = 1'b0;
    check_eq({tag, "_pulse"}, pulses, 3'(3'b001 << sel));
    check_eq({tag, "_st_cmplt"}, dbg_state, ST_CMPLT);
    check_eq({tag, "_valid_drop"}, snap_bus.o_snap_valid, 1'b0);
    set_ready(sel, 1'b0);
    tick();
    check_eq({tag, "_pulse_end"}, pulses, 3'b000);
    tick();
    check_eq({tag, "_st_idle"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    prog_ready = 1'b0; read_ready = 1'b0; erase_ready = 1'b0;
    prog_cnt = '0; read_cnt = '0; erase_cnt = '0;
    prog_req = '0; read_req = '0; erase_req = '0;
    snap_bus.i_snap_ack = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", snap_bus.o_snap_valid, 1'b0);
    check_eq("rst_sel", snap_bus.o_snap_sel, 2'd0);
    check_eq("rst_sum", snap_bus.o_snap_sum, 32'd0);
    check_eq("rst_req", snap_bus.o_snap_req_cnt, 12'd0);
    check_eq("rst_pulses", pulses, 3'b000);
`ifdef PERF_AVG_DIV_EN
    check_eq("rst_avg", snap_bus.o_snap_avg, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Ack while idle is ignored
    snap_bus.i_snap_ack = 1'b1;
    tick();
    tick();
    check_eq("idle_ack_state", dbg_state, ST_IDLE);
    check_eq("idle_ack_pulses", pulses, 3'b000);
    check_eq("idle_ack_valid", snap_bus.o_snap_valid, 1'b0);
    snap_bus.i_snap_ack = 1'b0;

    // Single read with exact latency and held ready
    read_cnt   = 32'h1000;
    read_req   = 12'h010;
    read_ready = 1'b1;
    tick();
    check_eq("rd_busy", busy, 1'b1);
    for (int i = 0; i < LAT - 2; i++) tick();
    check_eq("rd_valid_early", snap_bus.o_snap_valid, 1'b0);
    tick();
    check_eq("rd_valid", snap_bus.o_snap_valid, 1'b1);
    check_eq("rd_sel", snap_bus.o_snap_sel, SEL_READ);
    check_eq("rd_sum", snap_bus.o_snap_sum, 32'h1000);
    check_eq("rd_req", snap_bus.o_snap_req_cnt, 12'h010);
`ifdef PERF_AVG_DIV_EN
    check_eq("rd_avg", snap_bus.o_snap_avg, 32'h100);
`endif
    read_cnt = 32'h2222;
    tick();
    check_eq("rd_stable_sum", snap_bus.o_snap_sum, 32'h1000);
    check_eq("rd_stable_valid", snap_bus.o_snap_valid, 1'b1);
    snap_bus.i_snap_ack = 1'b1;
    tick();
    snap_bus.i_snap_ack = 1'b0;
    check_eq("rd_pulse", pulses, 3'b010);
    tick();
    check_eq("rd_pulse_once", pulses, 3'b000);
    for (int i = 0; i < 3; i++) begin
      check_eq("rd_drop_wait", dbg_state, ST_DROP_WAIT);
      check_eq("rd_no_regrant", snap_bus.o_snap_valid, 1'b0);
      tick();
    end
    read_ready = 1'b0;
    tick();
    check_eq("rd_back_idle", dbg_state, ST_IDLE);
    tick();
    check_eq("rd_stay_idle", dbg_state, ST_IDLE);
    check_eq("rd_hold_sum", snap_bus.o_snap_sum, 32'h1000);

    // All three together from reset: prog, read, erase
    do_reset();
    prog_cnt  = 32'h111; prog_req  = 10'h3;
    read_cnt  = 32'h222; read_req  = 12'h5;
    erase_cnt = 32'h333; erase_req = 10'h7;
    prog_ready = 1'b1; read_ready = 1'b1; erase_ready = 1'b1;
    serve("rr_prog", SEL_PROG, 32'h111, 12'h3);
    serve("rr_read", SEL_READ, 32'h222, 12'h5);
    serve("rr_erase", SEL_ERASE, 32'h333, 12'h7);
    tick();
    check_eq("rr_done_idle", dbg_state, ST_IDLE);

    // Reset while presenting aborts, then the requester is re-granted
    prog_cnt   = 32'hABCD;
    prog_req   = 10'h1;
    prog_ready = 1'b1;
    for (int i = 0; i < LAT; i++) tick();
    check_eq("ab_valid", snap_bus.o_snap_valid, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("ab_valid_rst", snap_bus.o_snap_valid, 1'b0);
    check_eq("ab_pulses", pulses, 3'b000);
    check_eq("ab_state", dbg_state, ST_IDLE);
    check_eq("ab_sum_rst", snap_bus.o_snap_sum, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("ab_pulses_after", pulses, 3'b000);
    serve("ab_regrant", SEL_PROG, 32'hABCD, 12'h1);

`ifdef PERF_AVG_DIV_EN
    // Average: 1000/7 = 142, and divide by zero gives 0
    erase_cnt   = 32'd1000;
    erase_req   = 10'd7;
    erase_ready = 1'b1;
    for (int i = 0; i < LAT - 1; i++) tick();
    check_eq("avg_valid_early", snap_bus.o_snap_valid, 1'b0);
    tick();
    check_eq("avg_valid", snap_bus.o_snap_valid, 1'b1);
    check_eq("avg_142", snap_bus.o_snap_avg, 32'd142);
    serve("avg_a", SEL_ERASE, 32'd1000, 12'd7);
    read_cnt   = 32'd500;
    read_req   = 12'd0;
    read_ready = 1'b1;
    for (int i = 0; i < LAT; i++) tick();
    check_eq("avg_zero", snap_bus.o_snap_avg, 32'd0);
    serve("avg_b", SEL_READ, 32'd500, 12'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
